mode_counter: RTL and testbench
===============================

// Module: mode_counter
// PURPOSE
//  Parametrised event counter: runtime modulus, up/down direction, wrap or one-shot mode,
//  synchronous load/clear, level- or edge-qualified counting, and a registered terminal tick.
//  Drop-in successor for prescalers, timeouts and pulse counters in the board-level designs.
//  Sits between an event source (sig) and a control FSM consuming cnt_tick/done.
// PARAMETERS
//  WIDTH  8  counter, modulus and load width in bits
//  STEP   1  increment/decrement per qualified event; 1 <= STEP <= 2**WIDTH-1
//  EDGE   0  0: count every cycle sig=1; 1: count only on sig rising edge
// PORTS
//  CLK50MHZ  in   1      system clock; all logic on posedge
//  rst       in   1      asynchronous, active-high reset
//  clr       in   1      synchronous clear: cnt<=0, leave DONE
//  load      in   1      synchronous load of load_val, leave DONE
//  load_val  in   WIDTH  value loaded when load=1
//  cnt_en    in   1      counting enable
//  sig       in   1      counted signal
//  up        in   1      1: count up; 0: count down
//  mode      in   1      0: wrap (auto-reload); 1: one-shot
//  modulus   in   WIDTH  terminal value; count range 0..modulus
//  cnt       out  WIDTH  current count (registered)
//  cnt_tick  out  1      one-cycle pulse on terminal event (registered)
//  done      out  1      high while in DONE state (one-shot finished)
// BEHAVIOUR
//  - Reset (async): cnt=0, cnt_tick=0, done=0, state=RUN, sig_q=0.
//  - qual = EDGE ? (sig & ~sig_q) : sig; sig_q<=sig every cycle regardless of cnt_en/clr/load.
//    Edges while cnt_en=0 or in DONE are lost, not queued.
//  - step = cnt_en & qual & (state==RUN).
//  - Priority per edge: clr > load > step. clr/load force state=RUN, cnt_tick=0.
//  - Terminal event (step only): up: cnt+STEP > modulus, computed WIDTH+1 bits, no overflow;
//    down: cnt < STEP.
//  - Non-terminal step: cnt <= cnt+STEP (up) or cnt-STEP (down).
//  - Terminal, mode=0: cnt <= 0 (up) or modulus (down); cnt_tick=1 next cycle; state RUN.
//  - Terminal, mode=1: cnt holds; cnt_tick=1 next cycle; state -> DONE, done=1.
//  - cnt_tick high exactly one cycle per terminal event, same cycle new cnt visible;
//    back-to-back terminal events (modulus<STEP) give consecutive tick cycles.
//  - FSM: RUN --terminal & mode=1--> DONE; DONE --clr|load--> RUN. rst -> RUN.
//    In DONE: steps ignored, cnt frozen; mode/modulus changes do not leave DONE.
//  - cnt > modulus (modulus lowered or load_val > modulus): next up step is terminal;
//    down steps decrement normally until within range.
//  - modulus=0: up step always terminal; down step terminal when cnt < STEP.
//  - Latency: cnt/cnt_tick/done update on the clock edge sampling the inputs; no pipeline.
//  - rst asserted mid-operation clears all state immediately, independent of clock.
// TESTING
//  1. WIDTH=4,STEP=1,EDGE=0; modulus=9, up=1, mode=0, sig=cnt_en=1, 25 cycles ->
//     cnt 0..9,0..9,0..4; cnt_tick on the 10th and 20th steps (cnt=0 those cycles); done=0.
//  2. load_val=3 load, then up=0, mode=1, modulus=5, steps -> cnt 2,1,0; next step ->
//     cnt_tick 1 cycle, done=1, cnt stays 0 under further steps; load 4 -> done=0, cnt=4.
//  3. STEP=3, modulus=10, up, wrap -> cnt 0,3,6,9,0 (tick on 9->0); down -> 0->10 with tick.
//  4. EDGE=1: sig high 5 cycles -> cnt +1 only; sig toggling every cycle -> +1 per rise;
//     rise with cnt_en=0 -> no change.
//  5. Priority: clr+load+step same edge -> cnt=0; load+step -> cnt=load_val, no tick;
//     rst pulse between clock edges mid-count -> cnt=0, cnt_tick=0, done=0 before next edge.
//  6. cnt=8, modulus changed to 5, up step -> terminal: cnt=0, cnt_tick=1 (mode=0).

Source files
------------

// File: rtl/mode_counter_if.sv
// Control/status bundle between a mode_counter and the logic that drives and consumes it.
interface mode_counter_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             cnt_en;
  logic             sig;
  logic             up;
  logic             mode;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] cnt;
  logic             cnt_tick;
  logic             done;

  modport master (
    output clr, load, load_val, cnt_en, sig, up, mode, modulus,
    input  cnt, cnt_tick, done
  );

  modport slave (
    input  clr, load, load_val, cnt_en, sig, up, mode, modulus,
    output cnt, cnt_tick, done
  );
endinterface

// File: rtl/mode_counter.sv
// Event counter with runtime modulus, up/down, wrap or one-shot mode, load/clear,
// level- or edge-qualified counting and a registered terminal tick.
module mode_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1,
  parameter bit          EDGE  = 1'b0
) (
  input logic           CLK50MHZ,
  input logic           rst,
  mode_counter_if.slave bus
);

  typedef enum logic [0:0] {StRun, StDone} state_e;

  localparam logic [WIDTH:0] StepW = (WIDTH + 1)'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sig_q;
  logic             qual;
  logic             step;
  logic             terminal;
  logic [WIDTH:0]   sum_up;

  always_ff @(posedge CLK50MHZ or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      sig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      sig_q   <= bus.sig;
    end
  end

  always_comb begin
    qual   = EDGE ? (bus.sig & ~sig_q) : bus.sig;
    step   = bus.cnt_en & qual & (state_q == StRun);
    // One extra bit so the up-count compare cannot wrap.
    sum_up = {1'b0, cnt_q} + StepW;
    if (bus.up) begin
      terminal = sum_up > {1'b0, bus.modulus};
    end else begin
      terminal = {1'b0, cnt_q} < StepW;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;

    if (bus.clr) begin
      cnt_d   = '0;
      state_d = StRun;
    end else if (bus.load) begin
      cnt_d   = bus.load_val;
      state_d = StRun;
    end else if (step) begin
      if (terminal) begin
        tick_d = 1'b1;
        if (bus.mode) begin
          state_d = StDone;
        end else begin
          cnt_d = bus.up ? '0 : bus.modulus;
        end
      end else begin
        cnt_d = bus.up ? sum_up[WIDTH-1:0] : (cnt_q - StepW[WIDTH-1:0]);
      end
    end
  end

  always_comb begin
    bus.cnt      = cnt_q;
    bus.cnt_tick = tick_q;
    bus.done     = (state_q == StDone);
  end

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench: three parameterisations share one stimulus stream, each tracked by
// an arithmetic reference model; directed tables and sequences cover the corner cases.
module tb_mode_counter;

  localparam int W = 4;
  localparam int N = 3;
  localparam int unsigned STEPS [N] = '{1, 3, 1};
  localparam bit          EDGES [N] = '{1'b0, 1'b0, 1'b1};

  logic         CLK50MHZ = 1'b0;
  logic         rst      = 1'b1;
  logic         clr, load, cnt_en, sig, up, mode;
  logic [W-1:0] load_val, modulus;

  logic [W-1:0] d_cnt  [N];
  logic         d_tick [N];
  logic         d_done [N];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_cnt  [N];
  bit m_tick [N];
  bit m_done [N];
  bit m_sigq [N];

  always #10 CLK50MHZ = ~CLK50MHZ;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mode_counter_if #(.WIDTH(W)) bus_if ();
    assign bus_if.clr      = clr;
    assign bus_if.load     = load;
    assign bus_if.load_val = load_val;
    assign bus_if.cnt_en   = cnt_en;
    assign bus_if.sig      = sig;
    assign bus_if.up       = up;
    assign bus_if.mode     = mode;
    assign bus_if.modulus  = modulus;
    assign d_cnt[g]        = bus_if.cnt;
    assign d_tick[g]       = bus_if.cnt_tick;
    assign d_done[g]       = bus_if.done;

    mode_counter #(.WIDTH(W), .STEP(STEPS[g]), .EDGE(EDGES[g])) u_dut (
      .CLK50MHZ (CLK50MHZ),
      .rst      (rst),
      .bus      (bus_if.slave)
    );
  end

  typedef struct {
    bit       clr;
    bit       load;
    bit [3:0] load_val;
    bit       cnt_en;
    bit       sig;
    bit       up;
    bit       mode;
    bit [3:0] modulus;
    int       exp_cnt;
    bit       exp_tick;
    bit       exp_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k]  = 0;
      m_tick[k] = 1'b0;
      m_done[k] = 1'b0;
      m_sigq[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < N; k++) begin
      bit qual;
      int s;
      s    = int'(STEPS[k]);
      qual = EDGES[k] ? (sig && !m_sigq[k]) : sig;
      m_tick[k] = 1'b0;
      if (clr) begin
        m_cnt[k]  = 0;
        m_done[k] = 1'b0;
      end else if (load) begin
        m_cnt[k]  = int'(load_val);
        m_done[k] = 1'b0;
      end else if (cnt_en && qual && !m_done[k]) begin
        if (up ? (m_cnt[k] + s > int'(modulus)) : (m_cnt[k] - s < 0)) begin
          m_tick[k] = 1'b1;
          if (mode) m_done[k] = 1'b1;
          else      m_cnt[k]  = up ? 0 : int'(modulus);
        end else begin
          m_cnt[k] = up ? m_cnt[k] + s : m_cnt[k] - s;
        end
      end
      m_sigq[k] = sig;
    end
  endtask

  task automatic cycle();
    @(posedge CLK50MHZ);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #5;
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    clr = 0; load = 0; load_val = '0; cnt_en = 0; sig = 0; up = 1; mode = 0; modulus = '0;
  endtask

  vec_t vecs [13];

  initial begin
    // Table: load/down/one-shot, priority, modulus lowered below cnt (STEP=1, level)
    //            clr load lv en sig up mode mod  cnt tick done
    vecs[0]  = '{0, 1, 3, 0, 0, 0, 1, 5,  3, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 1, 0, 1, 5,  2, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 1, 0, 1, 5,  1, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 1, 0, 1, 5,  0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 1, 0, 1, 5,  0, 1, 1};
    vecs[5]  = '{0, 0, 0, 1, 1, 0, 1, 5,  0, 0, 1};
    vecs[6]  = '{0, 0, 0, 1, 1, 1, 0, 5,  0, 0, 1};
    vecs[7]  = '{0, 1, 4, 0, 0, 0, 1, 5,  4, 0, 0};
    vecs[8]  = '{1, 1, 7, 1, 1, 1, 0, 9,  0, 0, 0};
    vecs[9]  = '{0, 1, 6, 1, 1, 1, 0, 6,  6, 0, 0};
    vecs[10] = '{0, 1, 8, 0, 0, 1, 0, 9,  8, 0, 0};
    vecs[11] = '{0, 0, 0, 1, 1, 1, 0, 5,  0, 1, 0};
    vecs[12] = '{0, 0, 0, 1, 1, 1, 0, 5,  1, 0, 0};

    idle_inputs();
    model_reset();
    #15;
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("reset_cnt", d_cnt[k], 0);
      check("reset_tick", d_tick[k], 0);
      check("reset_done", d_done[k], 0);
    end

    // Wrap count 0..9 with modulus 9
    do_reset();
    modulus = 4'd9; up = 1; mode = 0; sig = 1; cnt_en = 1;
    for (int i = 1; i <= 25; i++) begin
      cycle();
      check("wrap_cnt", d_cnt[0], i % 10);
      check("wrap_tick", d_tick[0], (i % 10) == 0);
      check("wrap_done", d_done[0], 0);
    end

    do_reset();
    idle_inputs();
    for (int i = 0; i < 13; i++) begin
      clr = vecs[i].clr; load = vecs[i].load; load_val = vecs[i].load_val;
      cnt_en = vecs[i].cnt_en; sig = vecs[i].sig; up = vecs[i].up;
      mode = vecs[i].mode; modulus = vecs[i].modulus;
      cycle();
      check($sformatf("vec%0d_cnt", i), d_cnt[0], vecs[i].exp_cnt);
      check($sformatf("vec%0d_tick", i), d_tick[0], vecs[i].exp_tick);
      check($sformatf("vec%0d_done", i), d_done[0], vecs[i].exp_done);
    end

    // STEP=3: up wrap 0,3,6,9,0 then down 0 -> modulus
    do_reset();
    idle_inputs();
    modulus = 4'd10; up = 1; sig = 1; cnt_en = 1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check("step3_cnt", d_cnt[1], (3 * i) % 12);
      check("step3_tick", d_tick[1], i == 4);
    end
    up = 0;
    cycle();
    check("step3_down_cnt", d_cnt[1], 10);
    check("step3_down_tick", d_tick[1], 1);
    cycle();
    check("step3_down2_cnt", d_cnt[1], 7);
    check("step3_down2_tick", d_tick[1], 0);

    // Edge-qualified counting
    do_reset();
    idle_inputs();
    modulus = 4'd15; up = 1; cnt_en = 1; sig = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("edge_hold_cnt", d_cnt[2], 1);
    end
    for (int j = 0; j < 6; j++) begin
      sig = (j % 2 == 1);
      cycle();
      check("edge_toggle_cnt", d_cnt[2], 1 + (j + 1) / 2);
    end
    cnt_en = 0; sig = 0;
    cycle();
    sig = 1;
    cycle();
    check("edge_disabled_cnt", d_cnt[2], 4);
    cnt_en = 1;
    cycle();
    check("edge_no_rise_cnt", d_cnt[2], 4);

    // Async reset between edges while tick and done are high
    do_reset();
    idle_inputs();
    modulus = 4'd3; up = 1; mode = 1; cnt_en = 1; sig = 1;
    repeat (4) cycle();
    check("oneshot_cnt", d_cnt[0], 3);
    check("oneshot_tick", d_tick[0], 1);
    check("oneshot_done", d_done[0], 1);
    #4;
    rst = 1'b1;
    model_reset();
    #2;
    check("async_rst_cnt", d_cnt[0], 0);
    check("async_rst_tick", d_tick[0], 0);
    check("async_rst_done", d_done[0], 0);
    rst = 1'b0;

    // Randomised run against the model
    do_reset();
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      clr      = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom);
      cnt_en   = ($urandom_range(0, 3) != 0);
      sig      = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 7) == 0) up = ~up;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 15) == 0) modulus = W'($urandom);
      cycle();
      for (int k = 0; k < N; k++) begin
        check($sformatf("rand_cnt[%0d]", k), d_cnt[k], m_cnt[k]);
        check($sformatf("rand_tick[%0d]", k), d_tick[k], m_tick[k]);
        check($sformatf("rand_done[%0d]", k), d_done[k], m_done[k]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
